// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: one-hot FSM encodings
// and default sizing constants.
package rr_grant_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT   = 3'b010,
        ST_RELEASE = 3'b100
    } state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/rr_grant_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module rr_pick
    import rr_grant_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win_id,
    output logic               win_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr is always < NUM_REQ, so one subtraction is enough to wrap
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, optional hold limit and 2-cycle turnaround.
// Latency: request to grant 1 cycle. Backpressure: owner keeps the grant while its request stays high.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_W     = DEF_ID_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;
    logic               owner_req;
    logic               others_pend;
    logic               hold_hit;
    logic [ID_W-1:0]    ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (i_req),
        .ptr     (rr_ptr_q),
        .win_id  (pick_id),
        .win_vld (pick_vld)
    );

    assign owner_req   = i_req[gnt_id_q];
    assign others_pend = |(i_req & ~gnt_q);
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign ptr_next    = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d      = '0;
                gnt_id_d   = '0;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
                if (i_en && pick_vld) begin
                    state_d  = ST_GRANT;
                    gnt_d    = NUM_REQ'(1) << pick_id;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!i_en || !owner_req || (hold_hit && others_pend)) begin
                    state_d    = ST_RELEASE;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    rr_ptr_d   = ptr_next;
                    // enable and owner request still high means the hold limit revoked it
                    timeout_d  = i_en && owner_req;
                end else if (hold_hit) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                rr_ptr_d   = '0;
                hold_cnt_d = '0;
                gnt_d      = '0;
                gnt_id_d   = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = gnt_id_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

endmodule
